// File: rtl/f_sweep_ctrl.sv
// Sweep sequencer for the f datapath: steps y over [lo, hi], waits LAT cycles per
// sample for f to settle, then folds {a,b} into a rotating checksum and counts samples.
module f_sweep_ctrl #(
   parameter int WIDTH = 12,
   parameter int LAT   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   lo,
   input  logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   y_o,
   output logic [WIDTH-1:0]   x_o,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [WIDTH:0]     count,
   output logic [2*WIDTH-1:0] chk
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_DONE
   } state_t;

   localparam logic [3:0] LAT_C = 4'(LAT);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic [WIDTH-1:0]   x_q, x_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [3:0]         sc_q, sc_d;
   logic [WIDTH:0]     count_q, count_d;
   logic [2*WIDTH-1:0] chk_q, chk_d;
   logic               aborted_q, aborted_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         y_q       <= '0;
         x_q       <= '0;
         hi_q      <= '0;
         sc_q      <= '0;
         count_q   <= '0;
         chk_q     <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         y_q       <= y_d;
         x_q       <= x_d;
         hi_q      <= hi_d;
         sc_q      <= sc_d;
         count_q   <= count_d;
         chk_q     <= chk_d;
         aborted_q <= aborted_d;
      end
   end

   // x is kept in its own register so that it reads 0 out of reset yet tracks
   // y+1 (with wrap) from the first accepted start onwards.
   always_comb begin
      state_d   = state_q;
      y_d       = y_q;
      x_d       = x_q;
      hi_d      = hi_q;
      sc_d      = sc_q;
      count_d   = count_q;
      chk_d     = chk_q;
      aborted_d = aborted_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               hi_d      = hi;
               y_d       = lo;
               x_d       = lo + 1'b1;
               sc_d      = '0;
               count_d   = '0;
               chk_d     = '0;
               aborted_d = 1'b0;
               state_d   = (lo > hi) ? S_DONE : S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_IDLE;
            end else if (sc_q == LAT_C) begin
               chk_d   = {chk_q[2*WIDTH-2:0], chk_q[2*WIDTH-1]} ^ {a_i, b_i};
               count_d = count_q + 1'b1;
               if (y_q == hi_q) begin
                  state_d = S_DONE;
               end else begin
                  y_d  = y_q + 1'b1;
                  x_d  = x_q + 1'b1;
                  sc_d = '0;
               end
            end else begin
               sc_d = sc_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign y_o     = y_q;
   assign x_o     = x_q;
   assign busy    = (state_q == S_SETTLE);
   assign done    = (state_q == S_DONE);
   assign aborted = aborted_q;
   assign count   = count_q;
   assign chk     = chk_q;

endmodule

// File: tb/tb_f_sweep_ctrl.sv
// Bench for f_sweep_ctrl: three instances (LAT=0,1,3) each driving a stub f whose
// outputs a=x, b=y lag by LAT cycles; a closed-form per-cycle model checks every output.
module tb_f_sweep_ctrl;
   localparam int W  = 12;
   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         start_w   [NI];
   logic         abort_w   [NI];
   logic [W-1:0] lo_w      [NI];
   logic [W-1:0] hi_w      [NI];
   logic [W-1:0] y_w       [NI];
   logic [W-1:0] x_w       [NI];
   logic [W-1:0] a_w       [NI];
   logic [W-1:0] b_w       [NI];
   logic         busy_w    [NI];
   logic         done_w    [NI];
   logic         aborted_w [NI];
   logic [W:0]   count_w   [NI];
   logic [2*W-1:0] chk_w   [NI];

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int D = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
      f_sweep_ctrl #(.WIDTH(W), .LAT(D)) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .start   (start_w[gi]),
         .abort   (abort_w[gi]),
         .lo      (lo_w[gi]),
         .hi      (hi_w[gi]),
         .y_o     (y_w[gi]),
         .x_o     (x_w[gi]),
         .a_i     (a_w[gi]),
         .b_i     (b_w[gi]),
         .busy    (busy_w[gi]),
         .done    (done_w[gi]),
         .aborted (aborted_w[gi]),
         .count   (count_w[gi]),
         .chk     (chk_w[gi])
      );
      if (D == 0) begin : g_comb
         assign a_w[gi] = x_w[gi];
         assign b_w[gi] = y_w[gi];
      end else begin : g_pipe
         logic [2*W-1:0] pipe [D];
         always @(posedge clk) begin
            pipe[0] <= {x_w[gi], y_w[gi]};
            for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
         end
         assign {a_w[gi], b_w[gi]} = pipe[D-1];
      end
   end

   function automatic int lat_of(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
   endfunction

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Sweep model: expected outputs as a closed-form function of the cycle number
   logic [2*W-1:0] chkpre [0:4096];
   int m_sel, m_lo, m_hi, m_lat, m_ka;
   bit mon_en = 1'b0;
   int mon_c, done_c;
   int per, n, endc, s, e_y;
   bit e_busy, e_done, e_ab;

   always @(negedge clk) begin
      if (mon_en) begin
         mon_c++;
         if (mon_c >= 1) begin
            per = m_lat + 1;
            e_busy = 1'b0; e_done = 1'b0; e_ab = 1'b0;
            if (m_lo > m_hi) begin
               e_done = (mon_c == 1);
               s = 0;
               e_y = m_lo;
            end else begin
               n = m_hi - m_lo + 1;
               endc = n * per;
               if (m_ka > 0 && mon_c > m_ka) begin
                  e_ab = 1'b1;
                  s = (m_ka - 1) / per;
               end else if (mon_c <= endc) begin
                  e_busy = 1'b1;
                  s = (mon_c - 1) / per;
               end else begin
                  s = n;
                  e_done = (mon_c == endc + 1);
               end
               e_y = m_lo + ((s < n) ? s : n - 1);
            end
            check($sformatf("busy@c%0d", mon_c),    64'(busy_w[m_sel]),    64'(e_busy));
            check($sformatf("done@c%0d", mon_c),    64'(done_w[m_sel]),    64'(e_done));
            check($sformatf("aborted@c%0d", mon_c), 64'(aborted_w[m_sel]), 64'(e_ab));
            check($sformatf("count@c%0d", mon_c),   64'(count_w[m_sel]),   64'(s));
            check($sformatf("chk@c%0d", mon_c),     64'(chk_w[m_sel]),     64'(chkpre[s]));
            check($sformatf("y_o@c%0d", mon_c),     64'(y_w[m_sel]),       64'(e_y));
            check($sformatf("x_o@c%0d", mon_c),     64'(x_w[m_sel]),       64'((e_y + 1) % 4096));
            if (done_w[m_sel] && done_c < 0) done_c = mon_c;
         end
      end
   end

   task automatic run_sweep(input int sel, input int lo, input int hi, input int ka,
                            input int stray_c);
      int nn, total;
      logic [W-1:0] yy, xx;
      nn = (lo > hi) ? 0 : hi - lo + 1;
      chkpre[0] = '0;
      for (int j = 0; j < nn; j++) begin
         yy = W'(lo + j);
         xx = W'((lo + j + 1) % 4096);
         chkpre[j+1] = {chkpre[j][2*W-2:0], chkpre[j][2*W-1]} ^ {xx, yy};
      end
      @(posedge clk); #2;
      m_sel = sel; m_lo = lo; m_hi = hi; m_lat = lat_of(sel); m_ka = ka;
      done_c = -1; mon_c = -1; mon_en = 1'b1;
      start_w[sel] = 1'b1;
      lo_w[sel] = W'(lo);
      hi_w[sel] = W'(hi);
      total = (lo > hi) ? 1 : ((ka > 0) ? ka : nn * (m_lat + 1) + 1);
      for (int c = 1; c <= total + 3; c++) begin
         @(posedge clk); #2;
         start_w[sel] = (c == stray_c);
         if (c == stray_c) begin
            lo_w[sel] = W'(0);
            hi_w[sel] = W'(1000);
         end
         abort_w[sel] = (c == ka);
      end
      mon_en = 1'b0;
      start_w[sel] = 1'b0;
      abort_w[sel] = 1'b0;
      $display("sweep inst=%0d lat=%0d lo=%0d hi=%0d abort_edge=%0d: done_cycle=%0d count=%0d chk=0x%06h aborted=%0b",
               sel, lat_of(sel), lo, hi, ka, done_c, count_w[sel], chk_w[sel], aborted_w[sel]);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         start_w[i] = 1'b0; abort_w[i] = 1'b0; lo_w[i] = '0; hi_w[i] = '0;
      end
      #12;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_busy[%0d]", i),    64'(busy_w[i]),    64'd0);
         check($sformatf("rst_done[%0d]", i),    64'(done_w[i]),    64'd0);
         check($sformatf("rst_aborted[%0d]", i), 64'(aborted_w[i]), 64'd0);
         check($sformatf("rst_count[%0d]", i),   64'(count_w[i]),   64'd0);
         check($sformatf("rst_chk[%0d]", i),     64'(chk_w[i]),     64'd0);
         check($sformatf("rst_y[%0d]", i),       64'(y_w[i]),       64'd0);
         check($sformatf("rst_x[%0d]", i),       64'(x_w[i]),       64'd0);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;

      // single sample, LAT=0
      run_sweep(0, 5, 5, 0, 0);
      check("single_done_cycle", 64'(done_c), 64'd2);
      check("single_count", 64'(count_w[0]), 64'd1);
      check("single_chk", 64'(chk_w[0]), 64'h006005);

      // settle latency, LAT=3 with a 3-cycle stub
      run_sweep(2, 10, 12, 0, 0);
      check("lat3_done_cycle", 64'(done_c), 64'd13);
      check("lat3_count", 64'(count_w[2]), 64'd3);
      check("lat3_chk", 64'(chk_w[2]), 64'h039032);

      // full 12-bit range, LAT=1
      run_sweep(1, 0, 4095, 0, 0);
      check("full_done_cycle", 64'(done_c), 64'd8193);
      check("full_count", 64'(count_w[1]), 64'd4096);
      check("full_last_y", 64'(y_w[1]), 64'd4095);
      check("full_x_wrap", 64'(x_w[1]), 64'd0);

      // empty sweep
      run_sweep(0, 7, 3, 0, 0);
      check("empty_done_cycle", 64'(done_c), 64'd1);
      check("empty_count", 64'(count_w[0]), 64'd0);
      check("empty_chk", 64'(chk_w[0]), 64'd0);

      // abort on edge 5, then a clean restart
      run_sweep(0, 0, 99, 5, 0);
      check("abort_count", 64'(count_w[0]), 64'd4);
      check("abort_flag", 64'(aborted_w[0]), 64'd1);
      check("abort_no_done", 64'(done_c), 64'hFFFF_FFFF_FFFF_FFFF);
      run_sweep(0, 1, 3, 0, 0);
      check("restart_done_cycle", 64'(done_c), 64'd4);
      check("restart_aborted", 64'(aborted_w[0]), 64'd0);
      check("restart_count", 64'(count_w[0]), 64'd3);

      // start pulsed while busy is ignored
      run_sweep(2, 20, 22, 0, 3);
      check("stray_done_cycle", 64'(done_c), 64'd13);
      check("stray_count", 64'(count_w[2]), 64'd3);

      // asynchronous reset mid-sweep
      @(posedge clk); #2;
      start_w[0] = 1'b1; lo_w[0] = W'(0); hi_w[0] = W'(99);
      @(posedge clk); #2;
      start_w[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pre_reset_busy", 64'(busy_w[0]), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy",    64'(busy_w[0]),    64'd0);
      check("midrst_done",    64'(done_w[0]),    64'd0);
      check("midrst_aborted", 64'(aborted_w[0]), 64'd0);
      check("midrst_count",   64'(count_w[0]),   64'd0);
      check("midrst_chk",     64'(chk_w[0]),     64'd0);
      check("midrst_y",       64'(y_w[0]),       64'd0);
      check("midrst_x",       64'(x_w[0]),       64'd0);
      $display("mid-sweep reset: busy=%0b count=%0d y=%0d", busy_w[0], count_w[0], y_w[0]);
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/f_sweep_ctrl.md
# f_sweep_ctrl

Sequencer that drives the `f` datapath through a programmable contiguous range of `y` operands and presents `x = y + 1` alongside each one. It waits a configurable settle latency per sample, then folds the `a`/`b` results into a rotating checksum and counts samples. A start/busy/done handshake wraps each sweep, so one controller replaces the free-running stimulus loop. It sits between a host/test controller and a single `f` instance.

## Interface

Parameters:
- `WIDTH`, default 12: operand width of `x`, `y`, `a` and `b`.
- `LAT`, default 1: cycles the `f` outputs need to settle after `x`/`y` change. The legal range is 0..15.

Ports:
- `clk`, input, 1: the single clock. Every register updates on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous and active-low.
- `start`, input, 1: begins a sweep. It is sampled only in IDLE.
- `abort`, input, 1: ends a sweep early. It is sampled in SETTLE.
- `lo`, input, WIDTH: first `y` value. It is latched on an accepted start.
- `hi`, input, WIDTH: last `y` value, inclusive. It is latched on an accepted start.
- `y_o`, output, WIDTH: `y` operand driven to `f`.
- `x_o`, output, WIDTH: `x` operand driven to `f`. It equals `y_o + 1` modulo 2^WIDTH.
- `a_i`, input, WIDTH: `a` result returned by `f`.
- `b_i`, input, WIDTH: `b` result returned by `f`.
- `busy`, output, 1: high while a sweep is in progress.
- `done`, output, 1: one-cycle pulse when a sweep completes normally.
- `aborted`, output, 1: sticky flag, set when a sweep is aborted. It clears on the next accepted start.
- `count`, output, WIDTH+1: number of samples captured in the current or last sweep.
- `chk`, output, 2*WIDTH: rotating checksum of the captured `{a,b}` pairs.

## Operation

Reset values: all outputs and registers are 0 when `rst_n` is low, and the FSM is in IDLE.

FSM states are IDLE, SETTLE and DONE.

- **IDLE**
  - If `start=1`:
    - Latch `lo` and `hi`.
    - Clear `chk`, `count` and `aborted`.
    - Load `y_o` with `lo`.
    - Clear the settle counter `sc`.
  - If `lo > hi`, the sweep is empty: go to DONE, capturing nothing.
  - Otherwise go to SETTLE.
- **SETTLE**
  - `busy=1`. `y_o` and `x_o` are held stable for the whole sample.
  - While `sc < LAT`, increment `sc` each cycle.
  - When `sc == LAT`, capture the sample:
    - `chk <= {chk[2W-2:0], chk[2W-1]} ^ {a_i, b_i}`.
    - `count <= count + 1`.
    - If `y_o == hi`, go to DONE.
    - Otherwise set `y_o <= y_o + 1` and `sc <= 0`.
  - If `abort=1`:
    - Go to IDLE and set `aborted=1`.
    - Skip any capture in that cycle.
    - Leave `chk` and `count` holding the partial results.
    - Do not pulse `done`.
  - `abort` has priority over a capture in the same cycle.
- **DONE**
  - `done=1` and `busy=0` for exactly one cycle, then go to IDLE.

Arithmetic:
- `y_o` never wraps, because the sweep stops at `hi`. With WIDTH=12, `hi=4095` therefore works.
- `x_o` wraps: `y_o=4095` gives `x_o=0`.
- `count` is WIDTH+1 bits wide, so a full sweep of 4096 samples is representable.

Other rules:
- `start` in SETTLE or DONE is ignored.
- `abort` in IDLE or DONE is ignored.
- `chk` and `count` hold their values in IDLE until the next accepted start.

## Timing

- An accepted start is sampled on edge 0.
  - SETTLE begins at cycle 1, with `y_o=lo` and `busy=1`.
  - For an empty sweep, `done` is high in cycle 1 instead.
- Each sample occupies LAT+1 cycles, and the capture happens on the edge ending the last of them.
- For N = hi-lo+1 samples:
  - `busy` stays high for N*(LAT+1) cycles.
  - `done` is high in cycle N*(LAT+1)+1, with final `chk` and `count` already valid.
- There is no start-to-start overlap. The earliest restart is sampled in the cycle after `done`.
- On an abort sampled at edge k, `busy=0` and `aborted=1` from cycle k+1.
- Reset mid-sweep clears everything asynchronously. No `done` and no `aborted` are produced.

## Test plan

The bench uses a stub `f` with `a=x` and `b=y` unless noted otherwise.

- **Single sample:** LAT=0, lo=hi=5.
  - `busy` is high in cycle 1 only; `done` is high in cycle 2.
  - `count=1`, `chk=0x006005`.
- **Settle latency:** LAT=3, lo=10, hi=12.
  - Each `y_o` value is held 4 cycles; `done` is high in cycle 13; `count=3`.
  - The stub `f` delays its outputs by 3 cycles, and the captured pairs must match `x`/`y`.
- **Full 12-bit range:** LAT=1, lo=0, hi=4095.
  - `x_o=0` when `y_o=4095`.
  - `done` is high in cycle 8193; `count=4096`.
  - `chk` equals the bench's reference model.
- **Empty sweep:** lo=7, hi=3.
  - `done` is high in cycle 1, `busy` never rises, `count=0`, `chk=0`.
- **Abort:** LAT=0, lo=0, hi=99, with `abort` asserted on edge 5.
  - `count=4`, `aborted=1`, no `done` pulse.
  - A new start clears `aborted`, and the second sweep completes normally.
- **Reset and ignored start:**
  - `rst_n` driven low mid-sweep: all outputs go 0 immediately.
  - `start` pulsed while `busy`: ignored, and sweep results are unchanged.
